// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity codes, FSM
// state encoding and the default bit-period helper.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int DIV_W     = 16;
  localparam int BIT_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Bit period used when the runtime divisor is zero; truncated to 16 bits.
  function automatic logic [DIV_W-1:0] default_div(input int unsigned clk_freq,
                                                   input int unsigned bps);
    int unsigned q;
    q = clk_freq / bps;
    return q[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; read data is the entry at the
// read pointer, so a pop can latch it in the same cycle.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; flushing the pointers
  // and count is enough to make stale entries unreachable.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with runtime divisor, parity and stop-bit selection.
// Frame settings are captured at pop time so config edits never corrupt a frame.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [15:0]                   cfg_div,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy,
  output logic                          uart_txd
);

  localparam logic [DIV_W-1:0] DEF_DIV = default_div(CLK_FREQ, UART_BPS);
  localparam logic [BIT_IDX_W-1:0] LAST_DATA = BIT_IDX_W'(DATA_BITS - 1);

  tx_state_e             state;
  tx_state_e             state_next;
  logic [DIV_W-1:0]      bit_cnt;
  logic [BIT_IDX_W-1:0]  bit_idx;
  logic [DATA_BITS-1:0]  shreg;
  logic [DIV_W-1:0]      fr_div;
  logic [1:0]            fr_parity;
  logic                  fr_stop2;
  logic                  par_bit;

  logic [DATA_BITS-1:0]  fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  load;
  logic [DIV_W-1:0]      eff_div;
  logic                  parity_en;
  logic                  bit_end;
  logic                  last_stop;
  logic                  txd_next;
  logic                  busy_next;

  assign s_ready   = ~fifo_full;
  assign fifo_push = s_valid & s_ready;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .push    (fifo_push),
    .wr_data (s_data),
    .pop     (load),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign eff_div   = (cfg_div == '0) ? DEF_DIV : cfg_div;
  assign parity_en = (fr_parity == PAR_EVEN) || (fr_parity == PAR_ODD);
  assign bit_end   = (bit_cnt == fr_div - 16'd1);
  assign last_stop = (bit_idx == {{(BIT_IDX_W-1){1'b0}}, fr_stop2});

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_next;
  end

  // NOTE: defaults at the top of every combinational process keep every path
  // assigned, so no latch is inferred.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load       = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && bit_idx == LAST_DATA)
          state_next = parity_en ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (bit_end) state_next = ST_STOP;
      end
      ST_STOP: begin
        // Chaining straight into START keeps back-to-back frames gap-free.
        if (bit_end && last_stop) begin
          if (!fifo_empty) begin
            load       = 1'b1;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    txd_next  = 1'b1;
    busy_next = (state != ST_IDLE);
    case (state)
      ST_START:  txd_next = 1'b0;
      ST_DATA:   txd_next = shreg[0];
      ST_PARITY: txd_next = par_bit;
      default:   txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      fr_div    <= 16'd1;
      fr_parity <= PAR_NONE;
      fr_stop2  <= 1'b0;
      par_bit   <= 1'b0;
      uart_txd  <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      bit_cnt <= (state == ST_IDLE || bit_end) ? '0 : bit_cnt + 16'd1;

      if (state_next != state)
        bit_idx <= '0;
      else if (bit_end && (state == ST_DATA || state == ST_STOP))
        bit_idx <= bit_idx + 1'b1;

      if (load) begin
        shreg     <= fifo_rd_data;
        fr_div    <= eff_div;
        fr_parity <= cfg_parity;
        fr_stop2  <= cfg_stop2;
        par_bit   <= (cfg_parity == PAR_ODD) ? ~^fifo_rd_data : ^fifo_rd_data;
      end else if (state == ST_DATA && bit_end) begin
        shreg <= shreg >> 1;
      end

      uart_txd <= txd_next;
      tx_busy  <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame shapes, parity, stop bits, FIFO fill,
// default divisor, mid-frame config change and mid-frame reset.
module tb_uart_tx_cfg;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        s_valid;
  logic        s_ready;
  logic [DATA_BITS-1:0] s_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic        tx_busy;
  logic        uart_txd;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  uart_tx_cfg #(
    .CLK_FREQ   (50000000),
    .UART_BPS   (9600),
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cfg_div    (cfg_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .fifo_count (fifo_count),
    .tx_busy    (tx_busy),
    .uart_txd   (uart_txd)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [7:0] data);
    s_valid = 1'b1;
    s_data  = data;
    tick(1);
    s_valid = 1'b0;
  endtask

  task automatic wait_start(input int bound, input string tag);
    int n;
    n = 0;
    while (uart_txd !== 1'b0 && n < bound) begin
      n++;
      tick(1);
    end
    check({tag, " start_seen"}, 32'(n < bound), 32'd1);
  endtask

  // Called on the first sample of the start bit; leaves off one sample past the last stop.
  task automatic expect_frame(input logic [7:0] data, input bit has_par, input logic par_bit,
                              input bit stop2, input int div, input string tag);
    logic exp_bits[$];
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(data[i]);
    if (has_par) exp_bits.push_back(par_bit);
    exp_bits.push_back(1'b1);
    if (stop2) exp_bits.push_back(1'b1);
    foreach (exp_bits[b]) begin
      for (int c = 0; c < div; c++) begin
        check($sformatf("%s txd bit%0d clk%0d", tag, b, c), 32'(uart_txd), 32'(exp_bits[b]));
        check($sformatf("%s busy bit%0d clk%0d", tag, b, c), 32'(tx_busy), 32'd1);
        tick(1);
      end
    end
  endtask

  task automatic expect_idle(input string tag);
    check({tag, " idle txd"}, 32'(uart_txd), 32'd1);
    check({tag, " idle busy"}, 32'(tx_busy), 32'd0);
    check({tag, " idle count"}, 32'(fifo_count), 32'd0);
  endtask

  task automatic measure_run(input logic level, input int bound, output int n);
    n = 0;
    while (uart_txd === level && n < bound) begin
      n++;
      tick(1);
    end
  endtask

  initial begin
    int accepted;
    int run_len;
    int bad;

    sys_rst    = 1'b1;
    cfg_div    = 16'd4;
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    tick(3);
    sys_rst = 1'b0;
    check("reset txd", 32'(uart_txd), 32'd1);
    check("reset busy", 32'(tx_busy), 32'd0);
    check("reset count", 32'(fifo_count), 32'd0);
    check("reset ready", 32'(s_ready), 32'd1);
    tick(2);

    // 8N1, div 4, 0x55: exact push-to-start latency then 0,1,0,1,0,1,0,1,0,1.
    push_one(8'h55);
    check("lat count_after_push", 32'(fifo_count), 32'd1);
    check("lat txd_after_push", 32'(uart_txd), 32'd1);
    tick(1);
    check("lat count_after_pop", 32'(fifo_count), 32'd0);
    check("lat txd_after_pop", 32'(uart_txd), 32'd1);
    check("lat busy_after_pop", 32'(tx_busy), 32'd0);
    tick(1);
    expect_frame(8'h55, 1'b0, 1'b0, 1'b0, 4, "f55");
    expect_idle("f55 end");

    // Even parity of 0x07 is 1, odd parity is 0.
    cfg_parity = 2'b01;
    push_one(8'h07);
    wait_start(10, "even");
    expect_frame(8'h07, 1'b1, 1'b1, 1'b0, 4, "even07");
    expect_idle("even end");

    cfg_parity = 2'b10;
    push_one(8'h07);
    wait_start(10, "odd");
    expect_frame(8'h07, 1'b1, 1'b0, 1'b0, 4, "odd07");
    expect_idle("odd end");

    // Parity code 11 means no parity bit.
    cfg_parity = 2'b11;
    push_one(8'h81);
    wait_start(10, "par11");
    expect_frame(8'h81, 1'b0, 1'b0, 1'b0, 4, "par11");
    expect_idle("par11 end");

    // Two stop bits, two queued words: 8 high clocks then the next start.
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hA3;
    tick(1);
    s_data  = 8'h3C;
    tick(1);
    s_valid = 1'b0;
    wait_start(10, "stop2");
    expect_frame(8'hA3, 1'b0, 1'b0, 1'b1, 4, "stop2 a3");
    expect_frame(8'h3C, 1'b0, 1'b0, 1'b1, 4, "stop2 3c");
    expect_idle("stop2 end");
    cfg_stop2 = 1'b0;

    // Divisor changed during frame 1 only affects frame 2.
    cfg_div = 16'd4;
    s_valid = 1'b1;
    s_data  = 8'h0F;
    tick(1);
    s_data  = 8'hF0;
    tick(1);
    s_valid = 1'b0;
    tick(1);
    check("divchg start", 32'(uart_txd), 32'd0);
    cfg_div = 16'd6;
    expect_frame(8'h0F, 1'b0, 1'b0, 1'b0, 4, "divchg f1");
    expect_frame(8'hF0, 1'b0, 1'b0, 1'b0, 6, "divchg f2");
    expect_idle("divchg end");

    // FIFO fill: s_valid for 20 cycles at div 100 -> 17 accepted, full at 16.
    cfg_div  = 16'd100;
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h10 + i);
      if (s_ready) accepted++;
      tick(1);
    end
    s_valid = 1'b0;
    check("fill accepted", 32'(accepted), 32'd17);
    check("fill count", 32'(fifo_count), 32'd16);
    check("fill ready", 32'(s_ready), 32'd0);
    // Frame 1 (0x10) began 17 clocks ago; skip to the first clock of frame 2.
    tick(983);
    check("fill count_after_pop", 32'(fifo_count), 32'd15);
    check("fill ready_after_pop", 32'(s_ready), 32'd1);
    for (int k = 1; k < 17; k++) begin
      expect_frame(8'(8'h10 + k), 1'b0, 1'b0, 1'b0, 100, $sformatf("fill w%0d", k));
    end
    expect_idle("fill end");

    // Default divisor 50 MHz / 9600 = 5208; four words, reset during DATA.
    cfg_div = 16'd0;
    s_valid = 1'b1;
    s_data  = 8'h01;
    tick(1);
    s_data  = 8'h22;
    tick(1);
    s_data  = 8'h33;
    tick(1);
    s_data  = 8'h44;
    tick(1);
    s_valid = 1'b0;
    check("def queued", 32'(fifo_count), 32'd3);
    check("def in_start", 32'(uart_txd), 32'd0);
    // One start-bit clock has already been sampled.
    measure_run(1'b0, 6000, run_len);
    check("def start_len", 32'(run_len), 32'd5207);
    measure_run(1'b1, 6000, run_len);
    check("def bit0_len", 32'(run_len), 32'd5208);
    check("def in_bit1", 32'(uart_txd), 32'd0);

    // Reset mid-frame while a push is also offered: reset wins.
    sys_rst = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h99;
    tick(1);
    sys_rst = 1'b0;
    s_valid = 1'b0;
    check("rst txd", 32'(uart_txd), 32'd1);
    check("rst busy", 32'(tx_busy), 32'd0);
    check("rst count", 32'(fifo_count), 32'd0);
    check("rst ready", 32'(s_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== '0) bad++;
      tick(1);
    end
    check("rst quiet", 32'(bad), 32'd0);

    // Fresh push after reset sends a normal frame.
    cfg_div = 16'd4;
    push_one(8'h3A);
    wait_start(10, "post_rst");
    expect_frame(8'h3A, 1'b0, 1'b0, 1'b0, 4, "post_rst 3a");
    expect_idle("post_rst end");

    // div = 1: one clock per bit.
    cfg_div = 16'd1;
    push_one(8'hC6);
    wait_start(10, "div1");
    expect_frame(8'hC6, 1'b0, 1'b0, 1'b0, 1, "div1 c6");
    expect_idle("div1 end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, buffered UART transmitter for the SoC peripheral bus side. It replaces the fixed 8N1 edge-triggered sender with several additions:
- a valid/ready input stream and a power-of-two transmit FIFO;
- a runtime baud divisor;
- selectable parity and one or two stop bits;
- a configurable data width.

Frames drain back-to-back with no idle gap while the FIFO holds data.

## Interface
Parameters:
- CLK_FREQ, 50000000: system clock in Hz.
- UART_BPS, 9600: default baud rate, used when cfg_div = 0.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- FIFO_DEPTH, 16: transmit FIFO entries, a power of two, at least 2.

Ports:
- sys_clk, in, 1: the only clock.
- sys_rst, in, 1: reset, synchronous, active-high.
- cfg_div, in, 16: bit period in sys_clk cycles. 0 selects CLK_FREQ/UART_BPS.
- cfg_parity, in, 2: 00 none, 01 even, 10 odd, 11 none.
- cfg_stop2, in, 1: 1 selects two stop bits.
- s_valid, in, 1: input word valid.
- s_ready, out, 1: FIFO can accept a word.
- s_data, in, DATA_BITS: word to send, LSB first.
- fifo_count, out, $clog2(FIFO_DEPTH)+1: queued words, excluding the word on the line.
- tx_busy, out, 1: a frame is in progress.
- uart_txd, out, 1: serial output, idle high, registered.

## Operation
- Push: s_valid & s_ready at a rising edge writes s_data into the FIFO.
  - s_ready = !full, combinational from registered state.
  - There is no pass-through when full.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE with FIFO non-empty:
  - pop one word;
  - latch the word, the effective divisor, cfg_parity and cfg_stop2 into frame registers;
  - go to START.
  - Config changes during a frame have no effect until the next pop.
- START: uart_txd = 0 for one bit period.
- DATA: send DATA_BITS bits, LSB first, one bit period each. A bit index counter counts 0..DATA_BITS-1.
- PARITY: entered only if parity is enabled.
  - Even: bit = XOR of the data bits.
  - Odd: bit = inverted XOR of the data bits.
- STOP: uart_txd = 1 for 1 or 2 bit periods.
- At the end of the last stop period:
  - if the FIFO is non-empty, pop and go directly to START, so the next start bit follows with zero gap;
  - otherwise go to IDLE.
- Bit period: a 16-bit counter runs 0..div-1. The state or bit advances when the counter reaches div-1.
  - div = 1 is legal, giving one clock per bit.
  - Effective div = cfg_div, or CLK_FREQ/UART_BPS truncated to 16 bits when cfg_div = 0.
- tx_busy = (state != IDLE).
- uart_txd = 1 in IDLE.

## Timing
- Reset values: uart_txd = 1, tx_busy = 0, fifo_count = 0, s_ready = 1. FSM in IDLE, counters 0.
- Push at an empty FIFO in edge N: the FSM sees the word at edge N+1 and pops it. uart_txd falls and tx_busy rises after edge N+2.
- Frame length = div × (1 + DATA_BITS + P + S) clocks exactly, where P = 1 if parity is enabled and S = 1 or 2 stop bits.
- Simultaneous push and pop: fifo_count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count saturates at FIFO_DEPTH with s_ready = 0.
- sys_rst asserted mid-frame, at the next edge:
  - uart_txd = 1 and the FSM goes to IDLE;
  - the FIFO is flushed;
  - no partial frame resumes.
- sys_rst has priority over a simultaneous push.

## Structure
- The shared package uart_pkg holds:
  - the parity encoding constants (PAR_NONE, PAR_EVEN, PAR_ODD);
  - the FSM state typedef;
  - the default-divisor function.
- Sub-module uart_tx_fifo: a synchronous FIFO parametrised by width and depth, with push/pop/full/empty/count and synchronous active-high reset.
- The FSM, bit-period counter and shift register live in uart_tx_cfg.

## Test plan
- DATA_BITS = 8, cfg_div = 4, no parity, one stop bit; push 0x55 → uart_txd sequence 0,1,0,1,0,1,0,1,0,1, 4 clocks each. tx_busy high for exactly 40 clocks.
- cfg_parity = 01 with 0x07 → parity bit 1. cfg_parity = 10 with 0x07 → parity bit 0. cfg_stop2 = 1 → high for 8 clocks before the next start.
- cfg_div = 100, FIFO_DEPTH = 16, s_valid held for 20 cycles → exactly 17 words accepted, fifo_count = 16, s_ready = 0. All 17 frames appear back-to-back with no idle clock between a stop bit and the following start bit.
- cfg_div = 0 → bit period is 5208 clocks. Changing cfg_div mid-frame leaves the current frame unchanged and applies from the next frame.
- sys_rst pulsed during DATA with 3 words queued → uart_txd = 1 and fifo_count = 0 at the next edge. No further frames are sent until a new push.
